// File: rtl/icn_pkg.sv
// -----------------------------------------------------------------------------
// icn_pkg
// Constants and helpers shared by the interconnect crossbar, its senders and
// the per-lane receive FIFOs.
//   ICN_W      : crossbar lane width in bits
//   ICN_DEPTH  : default receive FIFO depth in entries
//   cnt_w()    : width of an occupancy counter able to hold 0..depth
// -----------------------------------------------------------------------------
package icn_pkg;

  localparam int ICN_W     = 128;
  localparam int ICN_DEPTH = 8;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/icn_recv_fifo_if.sv
// -----------------------------------------------------------------------------
// icn_recv_fifo_if
// Bundle between one crossbar receive lane, the receive FIFO and its consumer.
//   in_en / in_word        : word strobe and data from the crossbar lane
//   out_valid / out_word   : head entry presented to the consumer
//   out_ready              : consumer accepts the head entry
//   count                  : current occupancy
//   almost_full / overflow : stop hint and sticky drop flag for the sender
//   ovf_clr                : clears overflow
// Modport slave is the FIFO side; modport master is the lane/consumer side.
// -----------------------------------------------------------------------------
interface icn_recv_fifo_if
  import icn_pkg::*;
#(
  parameter int W     = ICN_W,
  parameter int DEPTH = ICN_DEPTH
);

  localparam int CW = cnt_w(DEPTH);

  logic          in_en;
  logic [W-1:0]  in_word;
  logic          out_valid;
  logic [W-1:0]  out_word;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          overflow;
  logic          ovf_clr;

  modport slave (
    input  in_en, in_word, out_ready, ovf_clr,
    output out_valid, out_word, count, almost_full, overflow
  );

  modport master (
    output in_en, in_word, out_ready, ovf_clr,
    input  out_valid, out_word, count, almost_full, overflow
  );

endinterface

// File: rtl/icn_sdp_ram.sv
// -----------------------------------------------------------------------------
// icn_sdp_ram
// DEPTH x W simple dual-port storage: one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data, mem[i_raddr] combinationally
// -----------------------------------------------------------------------------
module icn_sdp_ram
  import icn_pkg::*;
#(
  parameter int W     = ICN_W,
  parameter int DEPTH = ICN_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/icn_recv_fifo.sv
// -----------------------------------------------------------------------------
// icn_recv_fifo
// First-word-fall-through receive FIFO for one crossbar receive lane.
// Words strobed by in_en are queued; the head is presented combinationally
// from storage. When full, a push is still accepted if the head is popped in
// the same cycle; otherwise the word is dropped and the sticky overflow flag
// is raised.
//   clk  : clock, all state changes on its rising edge
//   clr  : synchronous active-high reset of pointers, count and flags
//   bus  : icn_recv_fifo_if slave modport (lane input, consumer output,
//          count / almost_full / overflow / ovf_clr)
// -----------------------------------------------------------------------------
module icn_recv_fifo
  import icn_pkg::*;
#(
  parameter int W     = ICN_W,
  parameter int DEPTH = ICN_DEPTH,
  parameter int AFULL = DEPTH - 2
) (
  input  logic            clk,
  input  logic            clr,
  icn_recv_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_afull;
  logic          r_ovf;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_we;
  logic [CW-1:0] w_count_nxt;
  logic [W-1:0]  w_rdata;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = (r_count != '0) && bus.out_ready;
  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign w_push = bus.in_en && (!w_full || w_pop);
  assign w_drop = bus.in_en && w_full && !w_pop;
  // clr wins over a push landing in the same cycle.
  assign w_we   = w_push && !clr;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_afull  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_afull <= (w_count_nxt >= CW'(AFULL));
      // A drop in the same cycle as ovf_clr keeps the flag set.
      if (w_drop)           r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
    end
  end

  icn_sdp_ram #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.in_word),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign bus.out_valid   = (r_count != '0);
  assign bus.out_word    = w_rdata;
  assign bus.count       = r_count;
  assign bus.almost_full = r_afull;
  assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_icn_recv_fifo.sv
// -----------------------------------------------------------------------------
// tb_icn_recv_fifo
// Directed self-checking bench for icn_recv_fifo (W=128, DEPTH=8, AFULL=6).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_icn_recv_fifo;

  localparam int W     = 128;
  localparam int DEPTH = 8;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  icn_recv_fifo_if #(.W(W), .DEPTH(DEPTH)) bus ();

  icn_recv_fifo #(.W(W), .DEPTH(DEPTH), .AFULL(DEPTH - 2)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_en     = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr      = 1'b1;
    idle_inputs();

    // Reset, then one idle cycle
    tick();
    clr = 1'b0;
    tick();
    chk("rst_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_count", 128'(bus.count), 128'(0));
    chk("rst_afull", 128'(bus.almost_full), 128'(0));
    chk("rst_ovf", 128'(bus.overflow), 128'(0));

    // Single word A5..A5; no same-cycle bypass
    bus.in_en   = 1'b1;
    bus.in_word = {16{8'hA5}};
    #1;
    chk("no_bypass", 128'(bus.out_valid), 128'(0));
    tick();
    bus.in_en = 1'b0;
    chk("a5_valid", 128'(bus.out_valid), 128'(1));
    chk("a5_word", bus.out_word, {16{8'hA5}});
    chk("a5_count", 128'(bus.count), 128'(1));
    bus.out_ready = 1'b1;
    tick();
    chk("a5_pop_count", 128'(bus.count), 128'(0));
    chk("a5_pop_valid", 128'(bus.out_valid), 128'(0));

    // Pop while empty: no underflow
    tick();
    bus.out_ready = 1'b0;
    chk("empty_pop_count", 128'(bus.count), 128'(0));

    // Fill 0..7, almost_full from count 6
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_en   = 1'b1;
      bus.in_word = 128'(i);
      tick();
      chk("fill_count", 128'(bus.count), 128'(i + 1));
      chk("fill_afull", 128'(bus.almost_full), 128'((i + 1) >= 6));
    end
    // Push 8 while full: dropped
    bus.in_word = 128'(8);
    tick();
    bus.in_en = 1'b0;
    chk("drop_count", 128'(bus.count), 128'(8));
    chk("drop_ovf", 128'(bus.overflow), 128'(1));
    chk("drop_head", bus.out_word, 128'(0));

    // Drain 0..7 in order
    bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_valid", 128'(bus.out_valid), 128'(1));
      chk("drain_word", bus.out_word, 128'(i));
      tick();
    end
    bus.out_ready = 1'b0;
    chk("drain_count", 128'(bus.count), 128'(0));
    chk("drain_afull", 128'(bus.almost_full), 128'(0));
    chk("ovf_sticky", 128'(bus.overflow), 128'(1));
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", 128'(bus.overflow), 128'(0));

    // Full with simultaneous push of 9 and pop
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_en   = 1'b1;
      bus.in_word = 128'(8'h10 + i);
      tick();
    end
    bus.in_word   = 128'(9);
    bus.out_ready = 1'b1;
    tick();
    chk("fullpp_count", 128'(bus.count), 128'(8));
    chk("fullpp_ovf", 128'(bus.overflow), 128'(0));
    // Drop together with ovf_clr: set wins
    bus.out_ready = 1'b0;
    bus.in_word   = 128'(8'hEE);
    bus.ovf_clr   = 1'b1;
    tick();
    chk("setwins_ovf", 128'(bus.overflow), 128'(1));
    chk("setwins_count", 128'(bus.count), 128'(8));
    bus.in_en = 1'b0;
    tick();
    bus.ovf_clr = 1'b0;
    chk("ovf_clr2", 128'(bus.overflow), 128'(0));
    bus.out_ready = 1'b1;
    for (int i = 1; i < DEPTH; i++) begin
      chk("fullpp_word", bus.out_word, 128'(8'h10 + i));
      tick();
    end
    chk("fullpp_last", bus.out_word, 128'(9));
    tick();
    bus.out_ready = 1'b0;
    chk("fullpp_empty", 128'(bus.count), 128'(0));

    // Continuous push/pop for 20 cycles with 2 entries primed
    bus.in_en   = 1'b1;
    bus.in_word = 128'(100);
    tick();
    bus.in_word = 128'(101);
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_word = 128'(102 + i);
      #1;
      chk("stream_word", bus.out_word, 128'(100 + i));
      tick();
      chk("stream_count", 128'(bus.count), 128'(2));
    end
    bus.in_en = 1'b0;
    chk("stream_tail0", bus.out_word, 128'(120));
    tick();
    chk("stream_tail1", bus.out_word, 128'(121));
    tick();
    bus.out_ready = 1'b0;
    chk("stream_empty", 128'(bus.count), 128'(0));

    // 3 stored with overflow set, then clr + ovf_clr (+push, +pop)
    bus.in_en = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      bus.in_word = 128'(8'h40 + i);
      tick();
    end
    bus.in_en     = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.out_ready = 1'b0;
    chk("pre_clr_count", 128'(bus.count), 128'(3));
    chk("pre_clr_ovf", 128'(bus.overflow), 128'(1));
    chk("pre_clr_head", bus.out_word, 128'(8'h45));
    clr           = 1'b1;
    bus.ovf_clr   = 1'b1;
    bus.in_en     = 1'b1;
    bus.in_word   = 128'(8'h77);
    bus.out_ready = 1'b1;
    tick();
    clr = 1'b0;
    idle_inputs();
    chk("clr_count", 128'(bus.count), 128'(0));
    chk("clr_valid", 128'(bus.out_valid), 128'(0));
    chk("clr_ovf", 128'(bus.overflow), 128'(0));
    chk("clr_afull", 128'(bus.almost_full), 128'(0));
    bus.in_en   = 1'b1;
    bus.in_word = 128'(5);
    tick();
    bus.in_en = 1'b0;
    chk("post_clr_valid", 128'(bus.out_valid), 128'(1));
    chk("post_clr_word", bus.out_word, 128'(5));
    chk("post_clr_count", 128'(bus.count), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
